// File: rtl/result_writer_pkg.sv
// Shared definitions for the result write-back path: FSM encoding and
// the matrix geometry defaults used by the controller and the ALU.
package result_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_COL_END = 2'd2,
    ST_DONE    = 2'd3
  } wr_state_t;

  localparam int ELEM_W_DEF = 19;
  localparam int ROWS_DEF   = 4;
  localparam int COLS_DEF   = 4;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO buffering ALU results ahead of the SRAM writer.
// The head element is presented combinationally so that a pop and the
// capture of its data happen on the same edge.
module result_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is legal only when a pop frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/result_writer.sv
// Write-back engine: buffers ALU results and commits them column by column
// to the result SRAM, signalling column and matrix completion.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int ELEM_W     = ELEM_W_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              res_valid,
  input  logic [ELEM_W-1:0] res_data,
  output logic              res_ready,
  output logic              ram_csn,
  output logic              ram_web,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ELEM_W-1:0] ram_din,
  output logic              col_done,
  output logic              all_done
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 1);
  localparam logic [CLW-1:0]    COL_LAST = CLW'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROWS_A   = ADDR_W'(ROWS);

  wr_state_t         state_reg;
  logic [RW-1:0]     row_cnt_reg;
  logic [CLW-1:0]    col_cnt_reg;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic [ELEM_W-1:0] fifo_dout;
  logic [ADDR_W-1:0] wr_addr;

  // Results are only taken while a matrix is in progress.
  assign res_ready  = !fifo_full && (state_reg != ST_IDLE);
  assign fifo_push  = res_valid && res_ready;
  assign fifo_pop   = (state_reg == ST_WRITE) && !fifo_empty;
  // A new matrix discards anything left over from the previous one.
  assign fifo_clear = (state_reg == ST_IDLE) && start;
  assign wr_addr    = ADDR_W'(col_cnt_reg) * ROWS_A + ADDR_W'(row_cnt_reg);

  result_fifo #(
    .WIDTH (ELEM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (fifo_push),
    .din   (res_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer: counters, registered SRAM strobes and completion pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      row_cnt_reg <= '0;
      col_cnt_reg <= '0;
      ram_csn     <= 1'b1;
      ram_web     <= 1'b1;
      ram_addr    <= '0;
      ram_din     <= '0;
      col_done    <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      // Strobes and pulses default inactive; address and data hold.
      ram_csn  <= 1'b1;
      ram_web  <= 1'b1;
      col_done <= 1'b0;
      all_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg   <= ST_WRITE;
            row_cnt_reg <= '0;
            col_cnt_reg <= '0;
          end
        end
        ST_WRITE: begin
          if (fifo_pop) begin
            ram_csn     <= 1'b0;
            ram_web     <= 1'b0;
            ram_addr    <= wr_addr;
            ram_din     <= fifo_dout;
            row_cnt_reg <= row_cnt_reg + RW'(1);
            if (row_cnt_reg == ROW_LAST) state_reg <= ST_COL_END;
          end
        end
        ST_COL_END: begin
          col_done    <= 1'b1;
          row_cnt_reg <= '0;
          if (col_cnt_reg == COL_LAST) begin
            state_reg <= ST_DONE;
          end else begin
            col_cnt_reg <= col_cnt_reg + CLW'(1);
            state_reg   <= ST_WRITE;
          end
        end
        ST_DONE: begin
          all_done  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
